// File: rtl/tick_bcd_pkg.sv
// -----------------------------------------------------------------------------
// tick_bcd_pkg
//   Shared definitions for the tick-driven BCD counter.
//   - BCD_W   : width of one decimal digit
//   - BCD_MAX : highest legal digit value (9)
//   - bcd_t   : one BCD digit
//   - clog2() : elaboration-time ceiling log2, used to size the prescaler
// -----------------------------------------------------------------------------
package tick_bcd_pkg;

   localparam int BCD_W = 4;

   typedef logic [BCD_W-1:0] bcd_t;

   localparam bcd_t BCD_MAX = 4'd9;

   // Ceiling log2; clog2(1) returns 0, callers clamp to a minimum width of 1.
   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return res;
   endfunction

endpackage : tick_bcd_pkg

// File: rtl/tick_bcd_counter_bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
//   One decade of the cascaded BCD counter.
//   Ports:
//     F10M  in   system clock (rising edge)
//     RESET in   asynchronous active-low reset, clears the digit
//     clr   in   synchronous clear, priority over cin
//     cin   in   increment request (all lower digits at 9 and a count event)
//     q     out  registered digit value, always 0..9
//     cout  out  carry into the next decade: cin while this digit holds 9
// -----------------------------------------------------------------------------
module bcd_digit
   import tick_bcd_pkg::*;
(
   input  logic F10M,
   input  logic RESET,
   input  logic clr,
   input  logic cin,
   output bcd_t q,
   output logic cout
);

   bcd_t q_q;
   bcd_t q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (cin) begin
         q_d = (q_q == BCD_MAX) ? bcd_t'(0) : bcd_t'(q_q + bcd_t'(1));
      end
   end

   always_ff @(posedge F10M or negedge RESET) begin
      if (!RESET) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q    = q_q;
   assign cout = cin & (q_q == BCD_MAX);

endmodule : bcd_digit

// File: rtl/tick_bcd_counter.sv
// -----------------------------------------------------------------------------
// tick_bcd_counter
//   Samples the F500KB divided clock in the F10M domain, detects its rising
//   edges, prescales them by PRESCALE and advances a DIGITS-wide cascaded BCD
//   counter. TICK pulses for one cycle per increment, OVF pulses together
//   with TICK when every digit wraps from 9 to 0.
//
//   Parameters:
//     DIGITS      number of BCD decades (1..8)
//     PRESCALE    F500KB rising edges per count increment
//     SYNC_STAGES synchroniser depth for F500KB (>= 2)
//
//   Ports:
//     F10M   in   system clock, all logic on its rising edge
//     RESET  in   asynchronous active-low reset
//     F500KB in   divided reference clock, asynchronous to F10M
//     EN     in   count enable (level); rises are discarded while low
//     CLR    in   synchronous clear, priority over counting
//     HOLD   in   (only with TICK_BCD_HOLD_EN) freeze the displayed value
//     BCD    out  count value, digit 0 in [3:0]
//     TICK   out  one-cycle pulse per increment
//     OVF    out  one-cycle pulse on all-digit wrap
//
//   Build option: define TICK_BCD_HOLD_EN to add the HOLD input. While HOLD
//   is high BCD shows a snapshot taken on the first HOLD cycle; the live
//   count, TICK and OVF keep running underneath.
//
//   Handshake: none. EN, CLR and HOLD are levels sampled every F10M edge;
//   TICK and OVF are single-cycle strobes with no back-pressure.
// -----------------------------------------------------------------------------
module tick_bcd_counter
   import tick_bcd_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int PRESCALE    = 500,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    F10M,
   input  logic                    RESET,
   input  logic                    F500KB,
   input  logic                    EN,
   input  logic                    CLR,
`ifdef TICK_BCD_HOLD_EN
   input  logic                    HOLD,
`endif
   output logic [BCD_W*DIGITS-1:0] BCD,
   output logic                    TICK,
   output logic                    OVF
);

   // PRESCALE=1 would give a zero-width counter; keep one bit, it stays 0.
   localparam int              PC_W    = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);

   // ---------------------------------------------------------------------------
   // Synchroniser and rising-edge detector. These keep running through CLR
   // and EN=0 so the edge history is always current when counting resumes.
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   rise;

   always_ff @(posedge F10M or negedge RESET) begin
      if (!RESET) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], F500KB};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

   // ---------------------------------------------------------------------------
   // Prescaler. inc is only raised when CLR is low, which is what drops a
   // wrap that coincides with a clear.
   // ---------------------------------------------------------------------------
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;
   logic            inc;

   always_comb begin
      pc_d = pc_q;
      inc  = 1'b0;
      if (CLR) begin
         pc_d = '0;
      end else if (EN && rise) begin
         if (pc_q == PC_LAST) begin
            pc_d = '0;
            inc  = 1'b1;
         end else begin
            pc_d = pc_q + PC_W'(1);
         end
      end
   end

   always_ff @(posedge F10M or negedge RESET) begin
      if (!RESET) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Cascaded decades: carry[g] is the increment into digit g.
   // ---------------------------------------------------------------------------
   logic [DIGITS:0]             carry;
   logic [BCD_W*DIGITS-1:0]     live_bcd;

   assign carry[0] = inc;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
         .F10M  (F10M),
         .RESET (RESET),
         .clr   (CLR),
         .cin   (carry[g]),
         .q     (live_bcd[g*BCD_W +: BCD_W]),
         .cout  (carry[g+1])
      );
   end

   // ---------------------------------------------------------------------------
   // Strobes: registered on the same edge the digits update.
   // ---------------------------------------------------------------------------
   logic tick_q;
   logic ovf_q;

   always_ff @(posedge F10M or negedge RESET) begin
      if (!RESET) begin
         tick_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         tick_q <= inc;
         ovf_q  <= carry[DIGITS];
      end
   end

   assign TICK = tick_q;
   assign OVF  = ovf_q;

`ifdef TICK_BCD_HOLD_EN
   // ---------------------------------------------------------------------------
   // Display hold. hold_q is the registered HOLD level; the snapshot is taken
   // on the edge where HOLD is first seen high, so the output mux only ever
   // selects between two registers.
   // ---------------------------------------------------------------------------
   logic                    hold_q;
   logic [BCD_W*DIGITS-1:0] held_q;

   always_ff @(posedge F10M or negedge RESET) begin
      if (!RESET) begin
         hold_q <= 1'b0;
         held_q <= '0;
      end else begin
         hold_q <= HOLD;
         if (HOLD && !hold_q) begin
            held_q <= live_bcd;
         end
      end
   end

   assign BCD = hold_q ? held_q : live_bcd;
`else
   assign BCD = live_bcd;
`endif

endmodule : tick_bcd_counter

// File: tb/tb_tick_bcd_counter.sv
// -----------------------------------------------------------------------------
// tb_tick_bcd_counter
//   Directed bench for tick_bcd_counter with DIGITS=2, PRESCALE=2,
//   SYNC_STAGES=2. F10M period 10 ns, F500KB period 200 ns (20 clocks).
//   With TICK_BCD_HOLD_EN defined the HOLD sequence is also exercised.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tick_bcd_counter;

   localparam int DIGITS      = 2;
   localparam int PRESCALE    = 2;
   localparam int SYNC_STAGES = 2;

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic       F10M = 1'b0;
   logic       RESET;
   logic       F500KB;
   logic       EN;
   logic       CLR;
`ifdef TICK_BCD_HOLD_EN
   logic       HOLD;
`endif
   logic [7:0] BCD;
   logic       TICK;
   logic       OVF;

   always #5 F10M = ~F10M;

   tick_bcd_counter #(
      .DIGITS      (DIGITS),
      .PRESCALE    (PRESCALE),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .F10M   (F10M),
      .RESET  (RESET),
      .F500KB (F500KB),
      .EN     (EN),
      .CLR    (CLR),
`ifdef TICK_BCD_HOLD_EN
      .HOLD   (HOLD),
`endif
      .BCD    (BCD),
      .TICK   (TICK),
      .OVF    (OVF)
   );

   int cyc = 0;
   always @(posedge F10M) cyc <= cyc + 1;

   // ---------------------------------------------------------------------------
   // Scoreboard counters and monitor (samples on the falling edge)
   // ---------------------------------------------------------------------------
   int   n_cmp = 0;
   int   n_err = 0;
   bit   mon_en = 1'b0;
   int   tick_cnt = 0;
   int   ovf_cnt = 0;
   int   wide_cnt = 0;
   int   ovf_alone = 0;
   logic prev_tick = 1'b0;
   int   tick_cyc_q[$];
   int   rise_cyc_q[$];

   always @(negedge F10M) begin
      if (mon_en) begin
         if (TICK === 1'b1) begin
            tick_cnt++;
            tick_cyc_q.push_back(cyc);
            if (prev_tick) wide_cnt++;
         end
         if (OVF === 1'b1) begin
            ovf_cnt++;
            if (TICK !== 1'b1) ovf_alone++;
         end
         prev_tick = (TICK === 1'b1);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Driver tasks. Callers sit just after a falling edge.
   // ---------------------------------------------------------------------------
   task automatic do_rises(input int n);
      for (int i = 0; i < n; i++) begin
         F500KB = 1'b1;
         rise_cyc_q.push_back(cyc);
         repeat (10) @(negedge F10M);
         F500KB = 1'b0;
         repeat (10) @(negedge F10M);
      end
   endtask

   task automatic clr_pulse();
      CLR = 1'b1;
      @(negedge F10M);
      CLR = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Vector table
   // ---------------------------------------------------------------------------
   typedef struct {
      int         rises;
      logic       en;
      logic [7:0] exp_bcd;
      int         exp_ticks;
      int         exp_ovfs;
      string      name;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int bad;
      int t0;
      int o0;
      int gaps_bad;

      vecs[0] = '{19,  1'b1, 8'h09, 9,  0, "carry_pre"};
      vecs[1] = '{1,   1'b1, 8'h10, 1,  0, "carry_09_10"};
      vecs[2] = '{178, 1'b1, 8'h99, 89, 0, "to_99"};
      vecs[3] = '{1,   1'b1, 8'h99, 0,  0, "pre_wrap"};
      vecs[4] = '{1,   1'b1, 8'h00, 1,  1, "ovf_wrap"};
      vecs[5] = '{1,   1'b1, 8'h00, 0,  0, "gate_pc1"};
      vecs[6] = '{6,   1'b0, 8'h00, 0,  0, "gate_off"};
      vecs[7] = '{1,   1'b1, 8'h01, 1,  0, "gate_on"};

      RESET  = 1'b1;
      F500KB = 1'b0;
      EN     = 1'b0;
      CLR    = 1'b0;
`ifdef TICK_BCD_HOLD_EN
      HOLD   = 1'b0;
`endif

      // ---- reset: immediate clear, outputs held at 0 while F500KB toggles
      #10 RESET = 1'b0;
      #1;
      check("reset_bcd",  32'(BCD),  32'h0);
      check("reset_tick", 32'(TICK), 32'h0);
      check("reset_ovf",  32'(OVF),  32'h0);
      EN  = 1'b1;
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge F10M);
         F500KB = ((i % 4) < 2);
         if (BCD !== 8'h00 || TICK !== 1'b0 || OVF !== 1'b0) bad++;
      end
      check("reset_hold", 32'(bad), 32'h0);
      F500KB = 1'b0;
      EN     = 1'b0;
      @(negedge F10M);
      RESET = 1'b1;
      repeat (5) @(negedge F10M);
      prev_tick = 1'b0;
      mon_en    = 1'b1;
      check("post_release_bcd", 32'(BCD), 32'h0);

      // ---- count: 10 rises -> 5 ticks, latency and spacing
      EN = 1'b1;
      tick_cnt = 0;
      tick_cyc_q.delete();
      rise_cyc_q.delete();
      do_rises(10);
      check("count_bcd",   32'(BCD),      32'h05);
      check("count_ticks", 32'(tick_cnt), 32'd5);
      if (tick_cyc_q.size() >= 1 && rise_cyc_q.size() >= 2)
         check("first_tick_latency", 32'(tick_cyc_q[0] - rise_cyc_q[1]), 32'(SYNC_STAGES + 1));
      else
         check("first_tick_latency", 32'hFFFF_FFFF, 32'(SYNC_STAGES + 1));
      gaps_bad = 0;
      for (int i = 1; i < tick_cyc_q.size(); i++)
         if (tick_cyc_q[i] - tick_cyc_q[i-1] != 40) gaps_bad++;
      check("tick_spacing", 32'(gaps_bad), 32'h0);

      // ---- plain clear, then table: decade carry, overflow, enable gating
      clr_pulse();
      check("clr_bcd", 32'(BCD), 32'h00);
      foreach (vecs[k]) begin
         EN = vecs[k].en;
         t0 = tick_cnt;
         o0 = ovf_cnt;
         do_rises(vecs[k].rises);
         check({vecs[k].name, "_bcd"},   32'(BCD),          32'(vecs[k].exp_bcd));
         check({vecs[k].name, "_ticks"}, 32'(tick_cnt - t0), 32'(vecs[k].exp_ticks));
         check({vecs[k].name, "_ovfs"},  32'(ovf_cnt - o0),  32'(vecs[k].exp_ovfs));
      end

      // ---- CLR on the exact wrap edge: wrap dropped, pc back to 0
      EN = 1'b1;
      do_rises(1);
      t0 = tick_cnt;
      F500KB = 1'b1;
      repeat (2) @(negedge F10M);
      CLR = 1'b1;
      @(negedge F10M);
      CLR = 1'b0;
      check("clrwrap_bcd",  32'(BCD),  32'h00);
      check("clrwrap_tick", 32'(TICK), 32'h0);
      repeat (7) @(negedge F10M);
      F500KB = 1'b0;
      repeat (10) @(negedge F10M);
      check("clrwrap_ticks", 32'(tick_cnt - t0), 32'h0);
      do_rises(1);
      check("clrwrap_r1_bcd",   32'(BCD),           32'h00);
      check("clrwrap_r1_ticks", 32'(tick_cnt - t0), 32'h0);
      do_rises(1);
      check("clrwrap_r2_bcd",   32'(BCD),           32'h01);
      check("clrwrap_r2_ticks", 32'(tick_cnt - t0), 32'h1);

`ifdef TICK_BCD_HOLD_EN
      // ---- display hold
      clr_pulse();
      do_rises(24);
      check("hold_pre_bcd", 32'(BCD), 32'h12);
      HOLD = 1'b1;
      t0 = tick_cnt;
      do_rises(8);
      check("hold_bcd",   32'(BCD),           32'h12);
      check("hold_ticks", 32'(tick_cnt - t0), 32'd4);
      HOLD = 1'b0;
      @(negedge F10M);
      check("hold_release_bcd", 32'(BCD), 32'h16);
`endif

      // ---- global strobe properties
      check("tick_width", 32'(wide_cnt),  32'h0);
      check("ovf_with_tick", 32'(ovf_alone), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_tick_bcd_counter
